// File: rtl/subsurf_pkg.sv
// Shared types and sizes for the subdivision result path.
// Holds the RES RAM geometry, the reader FSM encoding and the buffered word record.
package subsurf_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int RES_DEPTH = 512;

    typedef enum logic [1:0] {
        RR_IDLE,
        RR_READ,
        RR_DRAIN,
        RR_FINISH
    } res_reader_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } res_word_t;

endpackage

// File: rtl/res_reader_if.sv
// Valid/ready word stream from the RES reader toward the host/IO side.
// The master drives valid/data/last; the slave drives ready.
interface res_reader_if #(
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/res_reader_buf.sv
// Two-entry FIFO of res_word_t feeding the output stream; head is registered.
// Latency: a pushed word is visible at out the cycle after push.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module res_reader_buf
    import subsurf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  res_word_t in,
    output res_word_t out,
    output logic [1:0] occupancy
);

    res_word_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;
    logic      do_push;
    logic      do_pop;

    assign do_pop  = pop && (occupancy != 2'd0);
    assign do_push = push && ((occupancy != 2'd2) || do_pop);
    assign out     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occupancy <= occupancy + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/res_reader.sv
// Drains word_count words of the RES RAM from address 0 onto a valid/ready stream.
// Latency: first word valid 2 cycles after the start edge; 1 word/cycle with ready held.
// Backpressure: reads are issued only when the 2-entry buffer can absorb them.
// Optional RES_READER_CHECKSUM_EN adds a running sum of accepted words.
module res_reader
    import subsurf_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    output logic              RAM_RES_EN,
    output logic [ADDR_W-1:0] RAM_RES_A,
    output logic [3:0]        RAM_RES_WE,
    output logic [DATA_W-1:0] RAM_RES_Di,
    input  logic [DATA_W-1:0] RAM_RES_Do,
    res_reader_if.master      m,
    output logic              busy,
    output logic              done
`ifdef RES_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]      BUF_FULL  = 2'(BUF_DEPTH);

    res_reader_state_t state, state_nxt;

    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   wc_clamped;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_a_q;
    logic              inflight;
    logic              inflight_last;
    logic              start_ok;
    logic              issue;
    logic              pop;
    logic              drain_done;
    logic [1:0]        occupancy;
    res_word_t         buf_in;
    res_word_t         buf_out;

    assign wc_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign start_ok   = (state == RR_IDLE) && start;
    assign pop        = m.m_valid && m.m_ready;

    // A same-cycle pop frees the slot the new read will land in two edges later,
    // which is what sustains one word per cycle; never issue with two words held.
    assign issue = (state == RR_READ) && (remaining != '0) && (occupancy != BUF_FULL) &&
                   ((({1'b0, occupancy} + {2'b00, inflight}) < 3'd2) || pop);

    assign drain_done = (occupancy == 2'd0) || ((occupancy == 2'd1) && pop);

    assign RAM_RES_EN = issue;
    assign RAM_RES_A  = issue ? rd_addr : ram_a_q;
    assign RAM_RES_WE = 4'b0000;
    assign RAM_RES_Di = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RR_IDLE;
            remaining     <= '0;
            rd_addr       <= '0;
            ram_a_q       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (start_ok) begin
                remaining <= wc_clamped;
                rd_addr   <= '0;
            end else if (issue) begin
                remaining     <= remaining - 1'b1;
                rd_addr       <= rd_addr + 1'b1;
                ram_a_q       <= rd_addr;
                inflight_last <= (remaining == ONE_WORD);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != RR_IDLE);
        done      = 1'b0;
        case (state)
            RR_IDLE: begin
                if (start) begin
                    state_nxt = (wc_clamped == '0) ? RR_FINISH : RR_READ;
                end
            end
            RR_READ: begin
                // Skip DRAIN when the last word leaves this very cycle so done
                // follows the final handshake by exactly one cycle.
                if ((remaining == '0) && !inflight) begin
                    state_nxt = drain_done ? RR_FINISH : RR_DRAIN;
                end
            end
            RR_DRAIN: begin
                if (drain_done) begin
                    state_nxt = RR_FINISH;
                end
            end
            RR_FINISH: begin
                done      = 1'b1;
                state_nxt = RR_IDLE;
            end
            default: state_nxt = RR_IDLE;
        endcase
    end

    always_comb begin
        buf_in      = '0;
        buf_in.last = inflight_last;
        buf_in.data = RAM_RES_Do;
    end

    res_reader_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .pop       (pop),
        .in        (buf_in),
        .out       (buf_out),
        .occupancy (occupancy)
    );

    assign m.m_valid = (occupancy != 2'd0);
    assign m.m_data  = buf_out.data;
    assign m.m_last  = buf_out.last;

`ifdef RES_READER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + m.m_data;
        end
    end
`endif

endmodule

// File: tb/tb_res_reader.sv
// Directed vector bench for res_reader with a behavioural RES RAM.
// Define RES_READER_CHECKSUM_EN to also exercise the checksum output.
module tb_res_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  word_count;
    logic        ram_en;
    logic [8:0]  ram_a;
    logic [3:0]  ram_we;
    logic [31:0] ram_di;
    logic [31:0] ram_do;
    logic        busy;
    logic        done;
    logic [31:0] mem [512];
`ifdef RES_READER_CHECKSUM_EN
    logic [31:0] checksum;
    logic [31:0] cs_at_done;
`endif

    res_reader_if #(.DATA_W(32)) m_if ();

    res_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .RAM_RES_EN (ram_en),
        .RAM_RES_A  (ram_a),
        .RAM_RES_WE (ram_we),
        .RAM_RES_Di (ram_di),
        .RAM_RES_Do (ram_do),
        .m          (m_if.master),
        .busy       (busy),
        .done       (done)
`ifdef RES_READER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_do <= mem[ram_a];
    end

    typedef struct {
        int         wc;
        logic [3:0] rdy;        // m_ready for cycle k is rdy[k%4]
        int         poke_k;     // cycle of an extra start pulse while busy, -1 none
        int         exp_beats;
        int         exp_first;  // cycle index of first m_valid, -1 none
        int         exp_done;   // cycle index of the done pulse
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int beats = 0;
        int issued = 0;
        int first_k = -1;
        int done_k = -1;
        int we_bad = 0;
        int full_issue = 0;
        int stab_bad = 0;
        int buffered;
        logic infl_prev = 1'b0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;

        @(negedge clk);
        word_count = v.wc[9:0];
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            start = (k == v.poke_k);
            if (start) word_count = 10'd3;
            m_if.m_ready = v.rdy[k % 4];
            #1;
            if (k == 0) check("busy_after_start", busy, 1);
            buffered = issued - (infl_prev ? 1 : 0) - beats;
            if (ram_we != 4'b0) we_bad++;
            if (ram_en) begin
                check("rd_addr", ram_a, issued);
                if (buffered >= 2) full_issue++;
                issued++;
            end
            infl_prev = ram_en;
            if (m_if.m_valid) begin
                if (first_k < 0) first_k = k;
                if (prev_stall && (m_if.m_data !== prev_data || m_if.m_last !== prev_last))
                    stab_bad++;
                if (m_if.m_ready) begin
                    check("beat_data", m_if.m_data, mem[beats]);
                    check("beat_last", m_if.m_last, (beats == v.exp_beats - 1));
                    beats++;
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
            if (done) begin
                done_k = k;
`ifdef RES_READER_CHECKSUM_EN
                cs_at_done = checksum;
`endif
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_cycle", done_k, v.exp_done);
        check("first_valid_cycle", first_k, v.exp_first);
        check("beat_count", beats, v.exp_beats);
        check("read_count", issued, v.exp_beats);
        check("we_nonzero_cycles", we_bad, 0);
        check("issue_with_2_buffered", full_issue, 0);
        check("stall_instability", stab_bad, 0);
        @(negedge clk);
        #1;
        check("busy_after_done", busy, 0);
        check("done_single_pulse", done, 0);
        check("valid_after_done", m_if.m_valid, 0);
    endtask

    vec_t vecs[6];
    int   seen;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        word_count   = '0;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 + i;

        vecs[0] = '{12,  4'b1111, -1, 12,  2, 14};
        vecs[1] = '{5,   4'b1001,  4, 5,   2, 12};
        vecs[2] = '{0,   4'b1111, -1, 0,  -1, 0};
        vecs[3] = '{1,   4'b1111, -1, 1,   2, 3};
        vecs[4] = '{512, 4'b1111, -1, 512, 2, 514};
        vecs[5] = '{700, 4'b1111, -1, 512, 2, 514};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_en", ram_en, 0);
        check("rst_addr", ram_a, 0);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_data", m_if.m_data, 0);
        check("rst_last", m_if.m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a 10-word drain, after 3 beats.
        @(negedge clk);
        word_count = 10'd10;
        start      = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        m_if.m_ready = 1'b1;
        seen         = 0;
        for (int k = 0; k < 50 && seen < 3; k++) begin
            #1;
            if (m_if.m_valid && m_if.m_ready) seen++;
            if (seen < 3) @(negedge clk);
        end
        check("midreset_beats_seen", seen, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_valid", m_if.m_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_en", ram_en, 0);
        run_vec('{4, 4'b1111, -1, 4, 2, 6});

`ifdef RES_READER_CHECKSUM_EN
        mem[0] = 32'd1;
        mem[1] = 32'd2;
        mem[2] = 32'd3;
        mem[3] = 32'hFFFF_FFFF;
        run_vec('{4, 4'b1111, -1, 4, 2, 6});
        check("checksum_at_done", cs_at_done, 32'h0000_0005);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
